// File: rtl/tfab_pkg.sv
// Shared constants for the ternary fabric: PT-5 trit codes, lane-array FSM states and the
// exec_hints bit positions used by the register block that configures the array.
package tfab_pkg;

    localparam logic [1:0] TRIT_ZERO = 2'd0;
    localparam logic [1:0] TRIT_POS  = 2'd1;
    localparam logic [1:0] TRIT_NEG  = 2'd2;

    localparam logic [7:0] PT5_MAX_VALID = 8'd242;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned ZERO_SKIP = 17;
    localparam int unsigned FREE_NEG  = 18;
    localparam int unsigned BRDCST    = 19;

endpackage

// File: rtl/pt5_decode.sv
// PT-5 byte decoder: one byte carries five base-3 digits, each mapped to a 2-bit signed trit.
// Bytes above 242 are not valid PT-5 codes and decode to all-zero trits.
module pt5_decode
    import tfab_pkg::*;
(
    input  logic [7:0] code,
    output logic [9:0] trits,
    output logic       invalid
);

    always_comb begin
        logic [7:0] rem;
        logic [1:0] digit;
        invalid = (code > PT5_MAX_VALID);
        rem     = invalid ? 8'd0 : code;
        trits   = '0;
        for (int k = 0; k < 5; k++) begin
            digit = 2'(rem % 8'd3);
            rem   = rem / 8'd3;
            case (digit)
                TRIT_POS: trits[2*k +: 2] = 2'b01;
                TRIT_NEG: trits[2*k +: 2] = 2'b11;
                default:  trits[2*k +: 2] = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/tgemm_lane_array.sv
// Parametrised ternary MAC lane array: streams PT-5 packed weight/input beats into LANES
// signed accumulators with lane masking, weight broadcast, zero-skip stats and saturation.
module tgemm_lane_array
    import tfab_pkg::*;
#(
    parameter int unsigned LANES    = 15,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned DEPTH_W  = 16,
    parameter bit          SATURATE = 1'b1,
    localparam int unsigned PT5_B   = (LANES + 4) / 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [DEPTH_W-1:0]     depth,
    input  logic [7:0]             lane_count,
    input  logic                   broadcast,
    input  logic                   zero_skip,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [8*PT5_B-1:0]     s_weight,
    input  logic [8*PT5_B-1:0]     s_input,
    output logic                   busy,
    output logic                   done,
    output logic [LANES*ACC_W-1:0] acc_out,
    output logic [LANES-1:0]       sat_flags,
    output logic [31:0]            skip_count,
    output logic                   decode_err
);

    localparam logic [ACC_W-1:0] ACC_ONE     = ACC_W'(1);
    localparam logic [ACC_W-1:0] ACC_MAX     = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN     = ~ACC_MAX;
    // Saturating mode clamps symmetrically, so the negative rail is -MAX rather than MIN.
    localparam logic [ACC_W-1:0] ACC_NEG_LIM = SATURATE ? (ACC_MIN + ACC_ONE) : ACC_MIN;

    logic [10*PT5_B-1:0] w_trits, i_trits;
    logic [PT5_B-1:0]    w_inv, i_inv;

    for (genvar b = 0; b < PT5_B; b++) begin : g_dec
        pt5_decode u_w_dec (
            .code    (s_weight[8*b +: 8]),
            .trits   (w_trits[10*b +: 10]),
            .invalid (w_inv[b])
        );
        pt5_decode u_i_dec (
            .code    (s_input[8*b +: 8]),
            .trits   (i_trits[10*b +: 10]),
            .invalid (i_inv[b])
        );
    end

    state_e                        state_q, state_d;
    logic [DEPTH_W-1:0]            beat_cnt_q, beat_cnt_d;
    logic [LANES-1:0]              lane_en_q, lane_en_d;
    logic                          bcast_q, bcast_d;
    logic                          zskip_q, zskip_d;
    logic [LANES-1:0][ACC_W-1:0]   acc_q, acc_d;
    logic [LANES-1:0]              sat_q, sat_d;
    logic [31:0]                   skip_q, skip_d;
    logic                          derr_q, derr_d;
    logic                          accept;

    always_comb begin
        logic [1:0] w_t, i_t;
        logic       p_nz, p_neg;
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        lane_en_d  = lane_en_q;
        bcast_d    = bcast_q;
        zskip_d    = zskip_q;
        acc_d      = acc_q;
        sat_d      = sat_q;
        skip_d     = skip_q;
        derr_d     = derr_q;
        accept     = 1'b0;
        w_t        = '0;
        i_t        = '0;
        p_nz       = 1'b0;
        p_neg      = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d      = '0;
                    sat_d      = '0;
                    skip_d     = '0;
                    derr_d     = 1'b0;
                    bcast_d    = broadcast;
                    zskip_d    = zero_skip;
                    beat_cnt_d = depth;
                    // k < lane_count also enforces the clamp to LANES.
                    for (int k = 0; k < LANES; k++) begin
                        lane_en_d[k] = (32'(lane_count) > 32'(k));
                    end
                    state_d = (depth == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                accept = s_valid;
                if (s_valid) begin
                    beat_cnt_d = beat_cnt_q - DEPTH_W'(1);
                    if (beat_cnt_q == DEPTH_W'(1)) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (accept) begin
            derr_d = derr_q | (|w_inv) | (|i_inv);
            for (int k = 0; k < LANES; k++) begin
                w_t   = bcast_q ? w_trits[1:0] : w_trits[2*k +: 2];
                i_t   = i_trits[2*k +: 2];
                p_nz  = (|w_t) & (|i_t);
                p_neg = w_t[1] ^ i_t[1];
                if (lane_en_q[k]) begin
                    if (!p_nz) begin
                        if (zskip_q) skip_d = skip_d + 32'd1;
                    end else if (!p_neg) begin
                        if (acc_q[k] == ACC_MAX) begin
                            sat_d[k] = 1'b1;
                            if (!SATURATE) acc_d[k] = ACC_MIN;
                        end else begin
                            acc_d[k] = acc_q[k] + ACC_ONE;
                        end
                    end else begin
                        if (acc_q[k] == ACC_NEG_LIM) begin
                            sat_d[k] = 1'b1;
                            if (!SATURATE) acc_d[k] = ACC_MAX;
                        end else begin
                            acc_d[k] = acc_q[k] - ACC_ONE;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            lane_en_q  <= '0;
            bcast_q    <= 1'b0;
            zskip_q    <= 1'b0;
            acc_q      <= '0;
            sat_q      <= '0;
            skip_q     <= '0;
            derr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            lane_en_q  <= lane_en_d;
            bcast_q    <= bcast_d;
            zskip_q    <= zskip_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            skip_q     <= skip_d;
            derr_q     <= derr_d;
        end
    end

    assign s_ready    = (state_q == StRun);
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign acc_out    = acc_q;
    assign sat_flags  = sat_q;
    assign skip_count = skip_q;
    assign decode_err = derr_q;

endmodule
